dcache_mshr: RTL and testbench
==============================

// Module: dcache_mshr
// PURPOSE
//  Miss Status Holding Register file; the responder side of the Dcache controller's miss interface.
//  Accepts up to 3 misses per cycle: load miss, store miss, dirty evict.
//  Issues one memory request per cycle and matches tagged memory responses.
//  Returns completed load/store fills to the controller's mem_wr write port.
// PARAMETERS
//  MSHR_DEPTH  8  number of entries (>=4)
//  TAG_W       4  memory tag width; tag 0 = no response
// PORTS
//  clock                 in   1      single clock
//  reset                 in   1      asynchronous, active-high
//  miss_en               in   3      alloc request per port: [0] load, [1] store, [2] evict
//  miss_addr             in   3x64   byte addr; bits[2:0] ignored
//  miss_data_in          in   3x64   store/evict data (port 0 don't-care)
//  inst_type             in   3x2    LOAD=0 STORE=1 EVICT=2
//  mshr_proc2mem_command in   3x2    BUS_LOAD=1 / BUS_STORE=2 per port
//  miss_dirty            in   3      dirty bit returned with fill
//  search_en             in   2      [0] load search, [1] store search
//  search_addr           in   2x64   search addr; bits[2:0] ignored
//  search_wr_data        in   64     store data merged on store-search hit
//  miss_addr_hit         out  2      search hit per port
//  mshr_valid            out  1      >=3 free entries
//  mshr_empty            out  1      no valid entry
//  proc2mem_command      out  2      BUS_NONE=0 / BUS_LOAD=1 / BUS_STORE=2
//  proc2mem_addr         out  64     request addr, bits[2:0]=0
//  proc2mem_data         out  64     store data for BUS_STORE
//  mem2proc_response     in   TAG_W  nonzero = request accepted with this tag
//  mem2proc_tag          in   TAG_W  nonzero = data for this tag
//  mem2proc_data         in   64     response data
//  mem_wr                out  1      fill valid to controller
//  mem_addr              out  64     fill addr
//  mem_data              out  64     fill data
//  mem_dirty             out  1      fill dirty bit
//  stored_mem_wr         in   1      controller accepted current fill
// BEHAVIOUR
//  Entry fields: valid, blk addr[63:3], data, type, dirty, tag, state.
//  Entry states: ISSUE -> WAIT -> DONE -> free.
//  EVICT entries: ISSUE -> free.
//  All outputs are combinational from registered state plus inputs.
//  Reset clears every entry. Post-reset outputs: mshr_valid=1, mshr_empty=1, miss_addr_hit=0,
//   proc2mem_command=BUS_NONE, proc2mem_addr/data=0, mem_wr=0, mem_addr/data=0, mem_dirty=0.
//  Reset mid-operation drops all entries. Later responses/tags match nothing and are ignored.
//  Alloc: each miss_en[k] takes the lowest free entry, ports in order 0,1,2, state ISSUE.
//   - miss_en while !mshr_valid is ignored (controller gates it).
//   - Slots freed this cycle are usable next cycle.
//  Search: compares blk addr against registered valid entries only. Same-cycle allocs never hit.
//   - miss_addr_hit[k] = search_en[k] & match.
//   - Store hit on a LOAD/STORE entry: data<=search_wr_data, type<=STORE, dirty<=1.
//   - Store hit on an EVICT-only match: no merge; hit still asserted.
//  Issue: lowest-index ISSUE entry drives the proc2mem request.
//   - Command: BUS_STORE for EVICT, else BUS_LOAD.
//   - Response nonzero: EVICT entry freed; otherwise tag<=response, state WAIT.
//   - Response 0: request held unchanged next cycle.
//  Response: tag match on a WAIT entry -> DONE.
//   - LOAD entry: data<=mem2proc_data.
//   - STORE entry: keeps merged store data (block = 1 word).
//   - Tag match on no entry is ignored. Response and tag in the same cycle are both handled.
//  Fill: lowest-index DONE entry drives mem_wr=1, mem_addr, mem_data.
//   - mem_dirty = 1 for STORE, 0 for LOAD.
//   - stored_mem_wr & mem_wr frees the entry next cycle. Otherwise the fill is held.
//  Same-address load+store allocated in one cycle: load gets the lower index and fills first,
//   so the dirty store fill lands last.
//  mshr_valid = free_count >= 3. Free count saturates at 0..MSHR_DEPTH, width clog2(MSHR_DEPTH+1).
// TESTING
//  Reset -> mshr_valid=1, mshr_empty=1, proc2mem_command=0, mem_wr=0.
//  Load miss 0x1008 at t0, response=3 at t1, tag=3 with data 0xAB at t3
//   -> t4: mem_wr=1, mem_addr=0x1008, mem_data=0xAB, mem_dirty=0; stored_mem_wr=1 -> mshr_empty=1.
//  Load miss 0x2000 pending, store search 0x2000 data 0x55
//   -> miss_addr_hit[1]=1; later fill mem_data=0x55, mem_dirty=1.
//  Evict 0x3000 data 0x77 -> BUS_STORE, addr 0x3000, data 0x77; response=5 -> entry freed, no mem_wr.
//  Fill 6 entries (2 cycles x 3 ports) -> mshr_valid=0; 7th miss_en ignored; one fill retired
//   -> mshr_valid stays 0 until free>=3.
//  Reset asserted while 2 WAIT entries outstanding, then tag returns -> no mem_wr, mshr_empty=1.

Source files
------------

// File: rtl/dcache_mshr.sv
// Miss Status Holding Register file: allocates up to three misses per cycle, issues one
// memory request per cycle, matches tagged responses and returns fills to the controller.
module dcache_mshr #(
    parameter int MSHR_DEPTH = 8,
    parameter int TAG_W      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            miss_en,
    input  logic [2:0][63:0]      miss_addr,
    input  logic [2:0][63:0]      miss_data_in,
    input  logic [2:0][1:0]       inst_type,
    input  logic [2:0][1:0]       mshr_proc2mem_command,
    input  logic [2:0]            miss_dirty,
    input  logic [1:0]            search_en,
    input  logic [1:0][63:0]      search_addr,
    input  logic [63:0]           search_wr_data,
    output logic [1:0]            miss_addr_hit,
    output logic                  mshr_valid,
    output logic                  mshr_empty,
    output logic [1:0]            proc2mem_command,
    output logic [63:0]           proc2mem_addr,
    output logic [63:0]           proc2mem_data,
    input  logic [TAG_W-1:0]      mem2proc_response,
    input  logic [TAG_W-1:0]      mem2proc_tag,
    input  logic [63:0]           mem2proc_data,
    output logic                  mem_wr,
    output logic [63:0]           mem_addr,
    output logic [63:0]           mem_data,
    output logic                  mem_dirty,
    input  logic                  stored_mem_wr
);
    localparam int IDX_W = $clog2(MSHR_DEPTH);
    localparam int CNT_W = $clog2(MSHR_DEPTH + 1);
    localparam logic [1:0] T_STORE   = 2'd1;
    localparam logic [1:0] T_EVICT   = 2'd2;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    logic [MSHR_DEPTH-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [60:0]           addr_q  [MSHR_DEPTH];
    logic [60:0]           addr_d  [MSHR_DEPTH];
    logic [63:0]           data_q  [MSHR_DEPTH];
    logic [63:0]           data_d  [MSHR_DEPTH];
    logic [1:0]            type_q  [MSHR_DEPTH];
    logic [1:0]            type_d  [MSHR_DEPTH];
    logic [TAG_W-1:0]      tag_q   [MSHR_DEPTH];
    logic [TAG_W-1:0]      tag_d   [MSHR_DEPTH];
    state_t                state_q [MSHR_DEPTH];
    state_t                state_d [MSHR_DEPTH];

    logic [CNT_W-1:0]      free_cnt;
    logic                  iss_found, fill_found, found;
    logic [IDX_W-1:0]      iss_idx, fill_idx;
    logic [MSHR_DEPTH-1:0] ld_match, st_match, taken;

    // Command encoding is implied by entry type and fill dirtiness by the STORE type.
    logic unused_inputs;
    assign unused_inputs = ^{mshr_proc2mem_command, miss_dirty, miss_addr[0][2:0],
                             miss_addr[1][2:0], miss_addr[2][2:0],
                             search_addr[0][2:0], search_addr[1][2:0]};

    genvar gi;
    generate
        for (gi = 0; gi < MSHR_DEPTH; gi++) begin : g_match
            assign ld_match[gi] = valid_q[gi] && (addr_q[gi] == search_addr[0][63:3]);
            assign st_match[gi] = valid_q[gi] && (addr_q[gi] == search_addr[1][63:3]);
        end
    endgenerate

    assign miss_addr_hit = {search_en[1] & (|st_match), search_en[0] & (|ld_match)};

    // Descending scan: the last write wins, leaving the lowest matching index.
    always_comb begin
        free_cnt   = '0;
        iss_found  = 1'b0;
        iss_idx    = '0;
        fill_found = 1'b0;
        fill_idx   = '0;
        for (int i = MSHR_DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_cnt = free_cnt + CNT_W'(1);
            if (valid_q[i] && state_q[i] == ST_ISSUE) begin
                iss_found = 1'b1;
                iss_idx   = IDX_W'(i);
            end
            if (valid_q[i] && state_q[i] == ST_DONE) begin
                fill_found = 1'b1;
                fill_idx   = IDX_W'(i);
            end
        end
    end

    assign mshr_valid = free_cnt >= CNT_W'(3);
    assign mshr_empty = free_cnt == CNT_W'(MSHR_DEPTH);

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        mem_wr           = fill_found;
        mem_addr         = '0;
        mem_data         = '0;
        mem_dirty        = 1'b0;
        if (iss_found) begin
            proc2mem_command = (type_q[iss_idx] == T_EVICT) ? BUS_STORE : BUS_LOAD;
            proc2mem_addr    = {addr_q[iss_idx], 3'b000};
            if (type_q[iss_idx] == T_EVICT) proc2mem_data = data_q[iss_idx];
        end
        if (fill_found) begin
            mem_addr  = {addr_q[fill_idx], 3'b000};
            mem_data  = data_q[fill_idx];
            mem_dirty = dirty_q[fill_idx];
        end
    end

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        addr_d  = addr_q;
        data_d  = data_q;
        type_d  = type_q;
        tag_d   = tag_q;
        state_d = state_q;
        taken   = '0;
        found   = 1'b0;

        if (iss_found && mem2proc_response != '0) begin
            if (type_q[iss_idx] == T_EVICT) begin
                valid_d[iss_idx] = 1'b0;
            end else begin
                tag_d[iss_idx]   = mem2proc_response;
                state_d[iss_idx] = ST_WAIT;
            end
        end

        // Tag return is applied before the store merge so merged data always wins.
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            if (mem2proc_tag != '0 && valid_q[i] && state_q[i] == ST_WAIT &&
                tag_q[i] == mem2proc_tag) begin
                state_d[i] = ST_DONE;
                if (type_q[i] != T_STORE) data_d[i] = mem2proc_data;
            end
            if (search_en[1] && st_match[i] && type_q[i] != T_EVICT) begin
                data_d[i]  = search_wr_data;
                type_d[i]  = T_STORE;
                dirty_d[i] = 1'b1;
            end
        end

        if (fill_found && stored_mem_wr) valid_d[fill_idx] = 1'b0;

        if (mshr_valid) begin
            for (int k = 0; k < 3; k++) begin
                found = 1'b0;
                for (int i = 0; i < MSHR_DEPTH; i++) begin
                    if (miss_en[k] && !found && !valid_q[i] && !taken[i]) begin
                        found      = 1'b1;
                        taken[i]   = 1'b1;
                        valid_d[i] = 1'b1;
                        addr_d[i]  = miss_addr[k][63:3];
                        data_d[i]  = miss_data_in[k];
                        type_d[i]  = inst_type[k];
                        dirty_d[i] = (inst_type[k] == T_STORE);
                        tag_d[i]   = '0;
                        state_d[i] = ST_ISSUE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
                type_q[i]  <= '0;
                tag_q[i]   <= '0;
                state_q[i] <= ST_ISSUE;
            end
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                addr_q[i]  <= addr_d[i];
                data_q[i]  <= data_d[i];
                type_q[i]  <= type_d[i];
                tag_q[i]   <= tag_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end
endmodule

// File: tb/tb_dcache_mshr.sv
// Bench for dcache_mshr: directed vector table, hand-written corner sequences, and
// randomized traffic checked against a slot-level behavioural model.
module tb_dcache_mshr;
    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       miss_en;
    logic [2:0][63:0] miss_addr, miss_data_in;
    logic [2:0][1:0]  inst_type, mshr_proc2mem_command;
    logic [2:0]       miss_dirty;
    logic [1:0]       search_en;
    logic [1:0][63:0] search_addr;
    logic [63:0]      search_wr_data;
    logic [1:0]       miss_addr_hit;
    logic             mshr_valid, mshr_empty;
    logic [1:0]       proc2mem_command;
    logic [63:0]      proc2mem_addr, proc2mem_data;
    logic [3:0]       mem2proc_response, mem2proc_tag;
    logic [63:0]      mem2proc_data;
    logic             mem_wr;
    logic [63:0]      mem_addr, mem_data;
    logic             mem_dirty;
    logic             stored_mem_wr;

    always #5 clock = ~clock;

    dcache_mshr #(.MSHR_DEPTH(8), .TAG_W(4)) dut (
        .clock(clock), .reset(reset), .miss_en(miss_en), .miss_addr(miss_addr),
        .miss_data_in(miss_data_in), .inst_type(inst_type),
        .mshr_proc2mem_command(mshr_proc2mem_command), .miss_dirty(miss_dirty),
        .search_en(search_en), .search_addr(search_addr), .search_wr_data(search_wr_data),
        .miss_addr_hit(miss_addr_hit), .mshr_valid(mshr_valid), .mshr_empty(mshr_empty),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
        .mem2proc_tag(mem2proc_tag), .mem2proc_data(mem2proc_data), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_dirty(mem_dirty),
        .stored_mem_wr(stored_mem_wr)
    );

    typedef struct packed {
        logic [1:0]  hit;
        logic        vld;
        logic        emp;
        logic [1:0]  cmd;
        logic [63:0] paddr;
        logic [63:0] pdata;
        logic        wr;
        logic [63:0] maddr;
        logic [63:0] mdata;
        logic        mdirty;
    } exp_t;

    typedef struct {
        logic [2:0]  men;
        logic [63:0] a0, a1, a2, d;
        logic [1:0]  sen;
        logic [63:0] sa, swd;
        logic [3:0]  resp, tg;
        logic [63:0] md;
        logic        smw;
        exp_t        e;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Model: each slot is FREE, or holds a miss in ISSUE/WAIT/DONE.
    localparam int FREE = 0, ISS = 1, WAITS = 2, DONE = 3;
    localparam int LOAD = 0, STORE = 1, EVICT = 2;
    int          m_st   [8];
    int          m_type [8];
    int          m_tag  [8];
    logic [63:0] m_addr [8];
    logic [63:0] m_data [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_st[i] = FREE; m_type[i] = 0; m_tag[i] = 0; m_addr[i] = '0; m_data[i] = '0;
        end
    endtask

    function automatic int lowest(input int st);
        for (int i = 0; i < 8; i++) if (m_st[i] == st) return i;
        return -1;
    endfunction

    function automatic int nfree();
        int n = 0;
        for (int i = 0; i < 8; i++) if (m_st[i] == FREE) n++;
        return n;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   is, fi;
        e  = '0;
        is = lowest(ISS);
        fi = lowest(DONE);
        for (int i = 0; i < 8; i++) begin
            if (m_st[i] != FREE && m_addr[i] == {search_addr[0][63:3], 3'b000} && search_en[0])
                e.hit[0] = 1'b1;
            if (m_st[i] != FREE && m_addr[i] == {search_addr[1][63:3], 3'b000} && search_en[1])
                e.hit[1] = 1'b1;
        end
        e.vld = nfree() >= 3;
        e.emp = nfree() == 8;
        if (is >= 0) begin
            e.cmd   = (m_type[is] == EVICT) ? 2'd2 : 2'd1;
            e.paddr = m_addr[is];
            e.pdata = (m_type[is] == EVICT) ? m_data[is] : 64'd0;
        end
        if (fi >= 0) begin
            e.wr     = 1'b1;
            e.maddr  = m_addr[fi];
            e.mdata  = m_data[fi];
            e.mdirty = (m_type[fi] == STORE);
        end
        return e;
    endfunction

    task automatic model_step();
        int          n_st [8];
        int          n_type [8];
        int          n_tag [8];
        logic [63:0] n_addr [8];
        logic [63:0] n_data [8];
        bit          used [8];
        int          is, fi;
        bit          can_alloc;
        n_st = m_st; n_type = m_type; n_tag = m_tag; n_addr = m_addr; n_data = m_data;
        is = lowest(ISS);
        fi = lowest(DONE);
        can_alloc = nfree() >= 3;
        if (is >= 0 && mem2proc_response != 0) begin
            if (m_type[is] == EVICT) n_st[is] = FREE;
            else begin n_st[is] = WAITS; n_tag[is] = int'(mem2proc_response); end
        end
        for (int i = 0; i < 8; i++) begin
            if (mem2proc_tag != 0 && m_st[i] == WAITS && m_tag[i] == int'(mem2proc_tag)) begin
                n_st[i] = DONE;
                if (m_type[i] == LOAD) n_data[i] = mem2proc_data;
            end
            if (search_en[1] && m_st[i] != FREE && m_type[i] != EVICT &&
                m_addr[i] == {search_addr[1][63:3], 3'b000}) begin
                n_data[i] = search_wr_data;
                n_type[i] = STORE;
            end
            used[i] = 1'b0;
        end
        if (fi >= 0 && stored_mem_wr) n_st[fi] = FREE;
        if (can_alloc) begin
            for (int k = 0; k < 3; k++) begin
                if (miss_en[k]) begin
                    for (int i = 0; i < 8; i++) begin
                        if (m_st[i] == FREE && !used[i]) begin
                            used[i] = 1'b1;
                            n_st[i] = ISS; n_type[i] = int'(inst_type[k]); n_tag[i] = 0;
                            n_addr[i] = {miss_addr[k][63:3], 3'b000};
                            n_data[i] = miss_data_in[k];
                            break;
                        end
                    end
                end
            end
        end
        m_st = n_st; m_type = n_type; m_tag = n_tag; m_addr = n_addr; m_data = n_data;
    endtask

    task automatic compare(input string p, input exp_t e);
        chk({p, " hit"},    64'(miss_addr_hit),    64'(e.hit));
        chk({p, " valid"},  64'(mshr_valid),       64'(e.vld));
        chk({p, " empty"},  64'(mshr_empty),       64'(e.emp));
        chk({p, " cmd"},    64'(proc2mem_command), 64'(e.cmd));
        chk({p, " paddr"},  proc2mem_addr,         e.paddr);
        chk({p, " pdata"},  proc2mem_data,         e.pdata);
        chk({p, " wr"},     64'(mem_wr),           64'(e.wr));
        chk({p, " maddr"},  mem_addr,              e.maddr);
        chk({p, " mdata"},  mem_data,              e.mdata);
        chk({p, " mdirty"}, 64'(mem_dirty),        64'(e.mdirty));
    endtask

    task automatic drive(input logic [2:0] men, input logic [63:0] a0, input logic [63:0] a1,
                         input logic [63:0] a2, input logic [63:0] d, input logic [1:0] sen,
                         input logic [63:0] sa, input logic [63:0] swd, input logic [3:0] resp,
                         input logic [3:0] tg, input logic [63:0] md, input logic smw);
        miss_en = men;
        miss_addr[0] = a0; miss_addr[1] = a1; miss_addr[2] = a2;
        miss_data_in[0] = d; miss_data_in[1] = d; miss_data_in[2] = d;
        search_en = sen; search_addr[0] = sa; search_addr[1] = sa; search_wr_data = swd;
        mem2proc_response = resp; mem2proc_tag = tg; mem2proc_data = md; stored_mem_wr = smw;
    endtask

    task automatic idle();
        drive(3'b0, 0, 0, 0, 0, 2'b0, 0, 0, 4'd0, 4'd0, 0, 1'b0);
    endtask

    // One cycle checked against the model; inputs must already be driven.
    task automatic mcyc(input string p);
        @(negedge clock);
        compare(p, model_out());
        $display("%s men=%b resp=%0d tag=%0d smw=%b cmd=%0d paddr=%h wr=%b maddr=%h mdata=%h",
                 p, miss_en, mem2proc_response, mem2proc_tag, stored_mem_wr,
                 proc2mem_command, proc2mem_addr, mem_wr, mem_addr, mem_data);
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        model_clear();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    function automatic vec_t V(input logic [2:0] men, input logic [63:0] a0, input logic [63:0] a1,
                               input logic [63:0] a2, input logic [63:0] d, input logic [1:0] sen,
                               input logic [63:0] sa, input logic [63:0] swd, input logic [3:0] resp,
                               input logic [3:0] tg, input logic [63:0] md, input logic smw,
                               input logic [1:0] hit, input logic vld, input logic emp,
                               input logic [1:0] cmd, input logic [63:0] paddr,
                               input logic [63:0] pdata, input logic wr, input logic [63:0] maddr,
                               input logic [63:0] mdata, input logic mdirty);
        vec_t v;
        v.men = men; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.d = d; v.sen = sen; v.sa = sa;
        v.swd = swd; v.resp = resp; v.tg = tg; v.md = md; v.smw = smw;
        v.e = '{hit: hit, vld: vld, emp: emp, cmd: cmd, paddr: paddr, pdata: pdata,
                wr: wr, maddr: maddr, mdata: mdata, mdirty: mdirty};
        return v;
    endfunction

    function automatic logic [63:0] rnd_addr();
        return 64'h8000 + 64'($urandom_range(0, 7) * 8) + 64'($urandom_range(0, 7));
    endfunction

    vec_t tbl [25];

    initial begin
        inst_type[0] = 2'd0; inst_type[1] = 2'd1; inst_type[2] = 2'd2;
        mshr_proc2mem_command[0] = 2'd1; mshr_proc2mem_command[1] = 2'd1;
        mshr_proc2mem_command[2] = 2'd2;
        miss_dirty = 3'b110;

        //            men  a0       a1     a2       d      sen sa       swd    rsp tag md      smw   hit vld emp cmd paddr    pdata  wr maddr    mdata  dty
        tbl[0]  = V(3'd0, 0,       0,     0,       0,     0, 0,       0,     0, 0, 0,      0,    0, 1, 1, 0, 0,       0,     0, 0,       0,     0);
        tbl[1]  = V(3'd1, 'h1008,  0,     0,       0,     0, 0,       0,     0, 0, 0,      0,    0, 1, 1, 0, 0,       0,     0, 0,       0,     0);
        tbl[2]  = V(3'd0, 0,       0,     0,       0,     0, 0,       0,     3, 0, 0,      0,    0, 1, 0, 1, 'h1008,  0,     0, 0,       0,     0);
        tbl[3]  = V(3'd0, 0,       0,     0,       0,     0, 0,       0,     0, 0, 0,      0,    0, 1, 0, 0, 0,       0,     0, 0,       0,     0);
        tbl[4]  = V(3'd0, 0,       0,     0,       0,     0, 0,       0,     0, 3, 'hAB,   0,    0, 1, 0, 0, 0,       0,     0, 0,       0,     0);
        tbl[5]  = V(3'd0, 0,       0,     0,       0,     0, 0,       0,     0, 0, 0,      1,    0, 1, 0, 0, 0,       0,     1, 'h1008,  'hAB,  0);
        tbl[6]  = V(3'd0, 0,       0,     0,       0,     0, 0,       0,     0, 0, 0,      0,    0, 1, 1, 0, 0,       0,     0, 0,       0,     0);
        tbl[7]  = V(3'd1, 'h2000,  0,     0,       0,     0, 0,       0,     0, 0, 0,      0,    0, 1, 1, 0, 0,       0,     0, 0,       0,     0);
        tbl[8]  = V(3'd0, 0,       0,     0,       0,     2, 'h2000,  'h55,  0, 0, 0,      0,    2, 1, 0, 1, 'h2000,  0,     0, 0,       0,     0);
        tbl[9]  = V(3'd0, 0,       0,     0,       0,     0, 0,       0,     4, 0, 0,      0,    0, 1, 0, 1, 'h2000,  0,     0, 0,       0,     0);
        tbl[10] = V(3'd0, 0,       0,     0,       0,     0, 0,       0,     0, 4, 'h99,   0,    0, 1, 0, 0, 0,       0,     0, 0,       0,     0);
        tbl[11] = V(3'd0, 0,       0,     0,       0,     0, 0,       0,     0, 0, 0,      0,    0, 1, 0, 0, 0,       0,     1, 'h2000,  'h55,  1);
        tbl[12] = V(3'd0, 0,       0,     0,       0,     0, 0,       0,     0, 0, 0,      1,    0, 1, 0, 0, 0,       0,     1, 'h2000,  'h55,  1);
        tbl[13] = V(3'd0, 0,       0,     0,       0,     0, 0,       0,     0, 0, 0,      0,    0, 1, 1, 0, 0,       0,     0, 0,       0,     0);
        tbl[14] = V(3'd4, 0,       0,     'h3000,  'h77,  3, 'h3000,  'h12,  0, 0, 0,      0,    0, 1, 1, 0, 0,       0,     0, 0,       0,     0);
        tbl[15] = V(3'd0, 0,       0,     0,       0,     3, 'h3005,  'h12,  0, 0, 0,      0,    3, 1, 0, 2, 'h3000,  'h77,  0, 0,       0,     0);
        tbl[16] = V(3'd0, 0,       0,     0,       0,     0, 0,       0,     5, 0, 0,      0,    0, 1, 0, 2, 'h3000,  'h77,  0, 0,       0,     0);
        tbl[17] = V(3'd0, 0,       0,     0,       0,     0, 0,       0,     0, 5, 'hEE,   0,    0, 1, 1, 0, 0,       0,     0, 0,       0,     0);
        tbl[18] = V(3'd7, 'h100,   'h200, 'h300,   0,     0, 0,       0,     0, 0, 0,      0,    0, 1, 1, 0, 0,       0,     0, 0,       0,     0);
        tbl[19] = V(3'd7, 'h400,   'h500, 'h600,   0,     0, 0,       0,     0, 0, 0,      0,    0, 1, 0, 1, 'h100,   0,     0, 0,       0,     0);
        tbl[20] = V(3'd1, 'h700,   0,     0,       0,     0, 0,       0,     0, 0, 0,      0,    0, 0, 0, 1, 'h100,   0,     0, 0,       0,     0);
        tbl[21] = V(3'd0, 0,       0,     0,       0,     0, 0,       0,     1, 0, 0,      0,    0, 0, 0, 1, 'h100,   0,     0, 0,       0,     0);
        tbl[22] = V(3'd0, 0,       0,     0,       0,     0, 0,       0,     0, 1, 'hC1,   0,    0, 0, 0, 1, 'h200,   0,     0, 0,       0,     0);
        tbl[23] = V(3'd0, 0,       0,     0,       0,     0, 0,       0,     0, 0, 0,      1,    0, 0, 0, 1, 'h200,   0,     1, 'h100,   'hC1,  0);
        tbl[24] = V(3'd0, 0,       0,     0,       0,     0, 0,       0,     0, 0, 0,      0,    0, 1, 0, 1, 'h200,   0,     0, 0,       0,     0);

        do_reset();
        for (int r = 0; r < 25; r++) begin
            drive(tbl[r].men, tbl[r].a0, tbl[r].a1, tbl[r].a2, tbl[r].d, tbl[r].sen, tbl[r].sa,
                  tbl[r].swd, tbl[r].resp, tbl[r].tg, tbl[r].md, tbl[r].smw);
            @(negedge clock);
            compare($sformatf("row%0d", r), tbl[r].e);
            $display("row%0d men=%b resp=%0d tag=%0d cmd=%0d paddr=%h wr=%b mdata=%h valid=%b",
                     r, miss_en, mem2proc_response, mem2proc_tag, proc2mem_command,
                     proc2mem_addr, mem_wr, mem_data, mshr_valid);
            model_step();
            @(posedge clock);
            #1;
        end

        // Same-address load and store in one cycle: load fill must land before the dirty store.
        do_reset();
        drive(3'd3, 'h4000, 'h4000, 0, 'h11, 0, 0, 0, 0, 0, 0, 0); mcyc("same_alloc");
        drive(3'd0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0);             mcyc("same_rsp8");
        drive(3'd0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0);             mcyc("same_rsp9");
        drive(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 'hD9, 0);          mcyc("same_tag9");
        drive(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 'hD8, 0);          mcyc("same_tag8");
        drive(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #3;
        chk("same first wr", 64'(mem_wr), 64'd1);
        chk("same first dirty", 64'(mem_dirty), 64'd0);
        chk("same first data", mem_data, 64'hD8);
        mcyc("same_fill0");
        #3;
        chk("same second dirty", 64'(mem_dirty), 64'd1);
        chk("same second data", mem_data, 64'h11);
        chk("same second addr", mem_addr, 64'h4000);
        mcyc("same_fill1");

        // Reset with two WAIT entries outstanding; their tags must then be ignored.
        do_reset();
        drive(3'd1, 'h5000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);        mcyc("rst_alloc0");
        drive(3'd1, 'h5008, 0, 0, 0, 0, 0, 0, 6, 0, 0, 0);        mcyc("rst_alloc1");
        drive(3'd0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0);             mcyc("rst_rsp7");
        idle();
        #3;
        chk("pre-reset empty", 64'(mshr_empty), 64'd0);
        reset = 1'b1;
        #1;
        chk("async reset empty", 64'(mshr_empty), 64'd1);
        chk("async reset valid", 64'(mshr_valid), 64'd1);
        model_clear();
        @(posedge clock);
        #1 reset = 1'b0;
        drive(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 'h66, 1);          mcyc("rst_tag6");
        drive(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 'h77, 1);          mcyc("rst_tag7");
        idle();
        #3;
        chk("post-reset tag wr", 64'(mem_wr), 64'd0);
        chk("post-reset tag empty", 64'(mshr_empty), 64'd1);
        mcyc("rst_idle");

        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [3:0] tg;
            int         w[$];
            tg = 4'd0;
            for (int i = 0; i < 8; i++) if (m_st[i] == WAITS) w.push_back(i);
            if ($urandom_range(0, 9) < 6 && w.size() > 0)
                tg = 4'(m_tag[w[$urandom_range(0, w.size() - 1)]]);
            else if ($urandom_range(0, 3) == 0)
                tg = 4'($urandom_range(1, 15));
            drive(3'($urandom_range(0, 7) & $urandom_range(0, 7)), rnd_addr(), rnd_addr(),
                  rnd_addr(), {$urandom, $urandom}, 2'($urandom_range(0, 3)), rnd_addr(),
                  {$urandom, $urandom},
                  ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0,
                  tg, {$urandom, $urandom}, ($urandom_range(0, 9) < 7));
            search_addr[0] = rnd_addr();
            mcyc($sformatf("rnd%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
